// File: rtl/mem_bank_arbiter.sv
// mem_bank_arbiter: shares one single-port memory bank between NUM_REQ requesters.
// Round-robin arbitration with an optional per-requester burst lock; the winner's
// command is steered onto the bank ports combinationally. A two-stage shadow pipeline
// tracks the bank's 2-cycle read latency and routes rvalid back to the issuer.
// The integrating level drives the bank's active-high reset from ~rst.
// Optional feature macro: MEM_ARB_PRIO0_EN (requester 0 has fixed priority in IDLE).
module mem_bank_arbiter #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 6,
    parameter int unsigned MAX_BURST  = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ-1:0]            lock,
    input  logic [NUM_REQ-1:0]            we,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] wdata,
    output logic [NUM_REQ-1:0]            gnt,
    output logic [NUM_REQ-1:0]            rvalid,
    output logic [DATA_WIDTH-1:0]         rdata,
    output logic                          mem_write_en,
    output logic                          mem_read_en,
    output logic [ADDR_WIDTH-1:0]         mem_addr,
    output logic [DATA_WIDTH-1:0]         mem_data_in,
    input  logic [DATA_WIDTH-1:0]         mem_data_out
);

    localparam int unsigned PtrW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned CntW = $clog2(MAX_BURST + 1);

    typedef enum logic [0:0] {StIdle, StOwned} state_e;

    state_e            state_q, state_d;
    logic [PtrW-1:0]   ptr_q, ptr_d;
    logic [PtrW-1:0]   owner_q, owner_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              s1_valid_q, s1_valid_d;
    logic [PtrW-1:0]   s1_id_q, s1_id_d;
    logic              s2_valid_q;
    logic [PtrW-1:0]   s2_id_q;

    logic              idle_found;
    logic [PtrW-1:0]   idle_win;
    logic              idle_ptr_upd;
    logic              gnt_valid;
    logic [PtrW-1:0]   gnt_id;

    // Successor of a requester index, wrapping at NUM_REQ (not necessarily a power of 2).
    function automatic logic [PtrW-1:0] wrap_inc(input logic [PtrW-1:0] v);
        return (v == PtrW'(NUM_REQ - 1)) ? '0 : v + PtrW'(1);
    endfunction

    // IDLE winner: first asserted req scanning upward from ptr.
    always_comb begin
        int unsigned idx;
        idle_found   = 1'b0;
        idle_win     = '0;
        idle_ptr_upd = 1'b1;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx = 32'(ptr_q) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!idle_found && req[PtrW'(idx)]) begin
                idle_found = 1'b1;
                idle_win   = PtrW'(idx);
            end
        end
`ifdef MEM_ARB_PRIO0_EN
        // Requester 0 overrides the rotation and leaves ptr untouched.
        if (req[0]) begin
            idle_found   = 1'b1;
            idle_win     = '0;
            idle_ptr_upd = 1'b0;
        end
`endif
    end

    // Arbitration FSM: grant selection, ownership and pointer next-state.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        owner_d   = owner_q;
        cnt_d     = cnt_q;
        gnt_valid = 1'b0;
        gnt_id    = '0;
        if (rst) begin
            unique case (state_q)
                StIdle: begin
                    if (idle_found) begin
                        gnt_valid = 1'b1;
                        gnt_id    = idle_win;
                        if (idle_ptr_upd) begin
                            ptr_d = wrap_inc(idle_win);
                        end
                        // With MAX_BURST=1 the first grant already exhausts the burst.
                        if (lock[idle_win] && (MAX_BURST > 1)) begin
                            state_d = StOwned;
                            owner_d = idle_win;
                            cnt_d   = CntW'(1);
                        end
                    end
                end
                StOwned: begin
                    if (req[owner_q]) begin
                        gnt_valid = 1'b1;
                        gnt_id    = owner_q;
                        cnt_d     = cnt_q + CntW'(1);
                        if (!lock[owner_q] || (cnt_d == CntW'(MAX_BURST))) begin
                            state_d = StIdle;
                            ptr_d   = wrap_inc(owner_q);
                        end
                    end else begin
                        state_d = StIdle;
                        ptr_d   = wrap_inc(owner_q);
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // Grant decode, bank command steering and read-return decode.
    always_comb begin
        gnt          = '0;
        mem_write_en = 1'b0;
        mem_read_en  = 1'b0;
        mem_addr     = '0;
        mem_data_in  = '0;
        rvalid       = '0;
        if (gnt_valid) begin
            gnt[gnt_id]  = 1'b1;
            mem_write_en = we[gnt_id];
            mem_read_en  = ~we[gnt_id];
            mem_addr     = addr[gnt_id*ADDR_WIDTH +: ADDR_WIDTH];
            mem_data_in  = wdata[gnt_id*DATA_WIDTH +: DATA_WIDTH];
        end
        if (rst && s2_valid_q) begin
            rvalid[s2_id_q] = 1'b1;
        end
    end

    assign rdata = mem_data_out;

    // Shadow pipeline entry: a granted read records who issued it.
    always_comb begin
        s1_valid_d = gnt_valid & ~we[gnt_id];
        s1_id_d    = gnt_id;
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= StIdle;
            ptr_q      <= '0;
            owner_q    <= '0;
            cnt_q      <= '0;
            s1_valid_q <= 1'b0;
            s1_id_q    <= '0;
            s2_valid_q <= 1'b0;
            s2_id_q    <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            owner_q    <= owner_d;
            cnt_q      <= cnt_d;
            s1_valid_q <= s1_valid_d;
            s1_id_q    <= s1_id_d;
            s2_valid_q <= s1_valid_q;
            s2_id_q    <= s1_id_q;
        end
    end

endmodule

// File: tb/tb_mem_bank_arbiter.sv
// Bench for mem_bank_arbiter: directed vector table plus randomized traffic checked
// against a behavioural model. Includes a 2-cycle-latency bank model.
module tb_mem_bank_arbiter;

    localparam int NR = 4;
    localparam int AW = 6;
    localparam int DW = 8;
    localparam int MB = 4;
`ifdef MEM_ARB_PRIO0_EN
    localparam bit PRIO0 = 1'b1;
`else
    localparam bit PRIO0 = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic [NR-1:0]     req, lock, we;
    logic [NR*AW-1:0]  addr;
    logic [NR*DW-1:0]  wdata;
    logic [NR-1:0]     gnt, rvalid;
    logic [DW-1:0]     rdata;
    logic              mem_write_en, mem_read_en;
    logic [AW-1:0]     mem_addr;
    logic [DW-1:0]     mem_data_in, mem_data_out;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mem_bank_arbiter #(
        .NUM_REQ   (NR),
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .MAX_BURST (MB)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .lock        (lock),
        .we          (we),
        .addr        (addr),
        .wdata       (wdata),
        .gnt         (gnt),
        .rvalid      (rvalid),
        .rdata       (rdata),
        .mem_write_en(mem_write_en),
        .mem_read_en (mem_read_en),
        .mem_addr    (mem_addr),
        .mem_data_in (mem_data_in),
        .mem_data_out(mem_data_out)
    );

    // Bank model: write at the edge, read data appears two cycles after the read edge.
    logic [DW-1:0] bmem [64];
    logic [DW-1:0] b_r1, b_r2;
    always @(posedge clk) begin
        if (!rst) begin
            b_r1 <= '0;
            b_r2 <= '0;
        end else begin
            if (mem_write_en) bmem[mem_addr] <= mem_data_in;
            if (mem_read_en) b_r1 <= bmem[mem_addr];
            b_r2 <= b_r1;
        end
    end
    assign mem_data_out = b_r2;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    typedef struct {
        string        nm;
        logic         r;
        logic [3:0]   rq, lk, wr;
        logic [23:0]  ad;
        logic [31:0]  wd;
        logic [3:0]   eg, erv;
        logic [7:0]   erd;
    } vec_t;

    function automatic vec_t mk(input string nm, input logic r, input logic [3:0] rq, lk, wr,
                                input logic [23:0] ad, input logic [31:0] wd,
                                input logic [3:0] eg, erv, input logic [7:0] erd);
        vec_t v;
        v.nm = nm; v.r = r; v.rq = rq; v.lk = lk; v.wr = wr; v.ad = ad; v.wd = wd;
        v.eg = eg; v.erv = erv; v.erd = erd;
        return v;
    endfunction

    // Drive one cycle of inputs, check mid-cycle, advance past the next edge.
    task automatic apply_vec(input vec_t v);
        rst = v.r; req = v.rq; lock = v.lk; we = v.wr; addr = v.ad; wdata = v.wd;
        #4;
        check({v.nm, ".gnt"}, 64'(gnt), 64'(v.eg));
        check({v.nm, ".rvalid"}, 64'(rvalid), 64'(v.erv));
        check({v.nm, ".mem_en"}, 64'({mem_write_en, mem_read_en}),
              64'({|(v.eg & v.wr), |(v.eg & ~v.wr)}));
        if (v.erv != 4'd0) check({v.nm, ".rdata"}, 64'(rdata), 64'(v.erd));
        @(posedge clk);
        #1;
    endtask

    localparam logic [23:0] ADR = {6'd3, 6'd2, 6'd1, 6'd0};
    localparam logic [23:0] ADW = {6'd3, 6'h10, 6'h10, 6'd0};
    localparam logic [31:0] PRE = 32'h44332211;
    localparam logic [31:0] WA5 = 32'h0000A500;

    typedef struct {
        int         due;
        int         id;
        logic [7:0] data;
    } rd_t;

    vec_t       tbl[$];
    rd_t        pend[$];
    rd_t        t_rd;
    logic [7:0] ref_mem [4];
    bit         m_owned;
    int         m_owner, m_ptr, m_cnt, cyc, w, a, j;
    logic [3:0] exp_gnt, exp_rv;
    logic [7:0] exp_rd;
    logic [15:0] exp_st;

    initial begin
        rst = 1'b0; req = '0; lock = '0; we = '0; addr = '0; wdata = '0;

        // Reset held with everyone requesting, then release and preload addrs 0..3.
        for (int k = 0; k < 3; k++) tbl.push_back(mk("reset", 0, 4'hF, 0, 0, ADR, 0, 0, 0, 0));
        tbl.push_back(mk("first_grant", 1, 4'hF, 0, 4'hF, ADR, PRE, 4'h1, 0, 0));
        tbl.push_back(mk("preload1", 1, 4'hE, 0, 4'hF, ADR, PRE, 4'h2, 0, 0));
        tbl.push_back(mk("preload2", 1, 4'hC, 0, 4'hF, ADR, PRE, 4'h4, 0, 0));
        tbl.push_back(mk("preload3", 1, 4'h8, 0, 4'hF, ADR, PRE, 4'h8, 0, 0));
        // Round-robin continuous reads.
        for (int k = 0; k < 8; k++) begin
            j = (k + 2) % 4;
            tbl.push_back(mk("rr", 1, 4'hF, 0, 0, ADR, 0,
                             PRIO0 ? 4'h1 : 4'(1 << (k % 4)),
                             (k < 2) ? 4'h0 : (PRIO0 ? 4'h1 : 4'(1 << j)),
                             PRIO0 ? 8'h11 : 8'(8'h11 * (j + 1))));
        end
        tbl.push_back(mk("rr_drain0", 1, 0, 0, 0, ADR, 0, 0, PRIO0 ? 4'h1 : 4'h4,
                         PRIO0 ? 8'h11 : 8'h33));
        tbl.push_back(mk("rr_drain1", 1, 0, 0, 0, ADR, 0, 0, PRIO0 ? 4'h1 : 4'h8,
                         PRIO0 ? 8'h11 : 8'h44));
        // Write then read of the same address on consecutive cycles.
        tbl.push_back(mk("wr", 1, 4'h2, 0, 4'h2, ADW, WA5, 4'h2, 0, 0));
        tbl.push_back(mk("rd_after_wr", 1, 4'h4, 0, 0, ADW, WA5, 4'h4, 0, 0));
        tbl.push_back(mk("rd_gap", 1, 0, 0, 0, ADW, 0, 0, 0, 0));
        tbl.push_back(mk("rd_return", 1, 0, 0, 0, ADW, 0, 0, 4'h4, 8'hA5));
        tbl.push_back(mk("rd_single", 1, 0, 0, 0, ADW, 0, 0, 0, 0));
        // Burst lock: req0 locked for MAX_BURST grants, then req1, then req0 again.
        tbl.push_back(mk("burst0", 1, 4'h3, 4'h1, 0, ADR, 0, 4'h1, 0, 0));
        tbl.push_back(mk("burst1", 1, 4'h3, 4'h1, 0, ADR, 0, 4'h1, 0, 0));
        tbl.push_back(mk("burst2", 1, 4'h3, 4'h1, 0, ADR, 0, 4'h1, 4'h1, 8'h11));
        tbl.push_back(mk("burst3", 1, 4'h3, 4'h1, 0, ADR, 0, 4'h1, 4'h1, 8'h11));
        tbl.push_back(mk("burst_release", 1, 4'h3, 4'h1, 0, ADR, 0, PRIO0 ? 4'h1 : 4'h2,
                         4'h1, 8'h11));
        tbl.push_back(mk("burst_again", 1, 4'h3, 4'h1, 0, ADR, 0, 4'h1, 4'h1, 8'h11));
        tbl.push_back(mk("burst_hold", 1, 4'h3, 4'h1, 0, ADR, 0, 4'h1, PRIO0 ? 4'h1 : 4'h2,
                         PRIO0 ? 8'h11 : 8'h22));
        // Owner drops req (releases), then reset lands mid-read.
        tbl.push_back(mk("owner_drop", 1, 0, 0, 0, ADR, 0, 0, 4'h1, 8'h11));
        tbl.push_back(mk("rd3", 1, 4'h8, 0, 0, ADR, 0, 4'h8, 4'h1, 8'h11));
        tbl.push_back(mk("rst_mid", 0, 4'hF, 0, 0, ADR, 0, 0, 0, 0));
        tbl.push_back(mk("rst_cancel", 1, 0, 0, 0, ADR, 0, 0, 0, 0));
        tbl.push_back(mk("rst_cancel2", 1, 0, 0, 0, ADR, 0, 0, 0, 0));
        // Requesters 0 and 1 continuous.
        for (int k = 0; k < 4; k++) begin
            tbl.push_back(mk("prio", 1, 4'h3, 0, 0, ADR, 0,
                             PRIO0 ? 4'h1 : 4'(1 << (k % 2)),
                             (k < 2) ? 4'h0 : (PRIO0 ? 4'h1 : 4'(1 << (k % 2))),
                             (PRIO0 || k == 2) ? 8'h11 : 8'h22));
        end

        @(posedge clk);
        #1;
        foreach (tbl[i]) apply_vec(tbl[i]);

        // Randomized traffic against the behavioural model, from a clean reset.
        rst = 1'b0; req = '0; lock = '0; we = '0;
        #4;
        @(posedge clk);
        #1;
        m_owned = 1'b0; m_owner = 0; m_ptr = 0; m_cnt = 0; cyc = 0;
        ref_mem[0] = 8'h11; ref_mem[1] = 8'h22; ref_mem[2] = 8'h33; ref_mem[3] = 8'h44;
        for (int n = 0; n < 3000; n++) begin
            rst  = ($urandom_range(99) != 0);
            req  = 4'($urandom);
            lock = 4'($urandom);
            we   = 4'($urandom);
            for (int i = 0; i < NR; i++) addr[i*AW +: AW] = 6'($urandom_range(3));
            wdata = $urandom;
            #4;
            // Expected winner from the arbitration rules.
            w = -1;
            if (rst) begin
                if (m_owned) begin
                    if (req[m_owner]) w = m_owner;
                end else if (PRIO0 && req[0]) begin
                    w = 0;
                end else begin
                    for (int k = 0; k < NR; k++) begin
                        if (w < 0 && req[(m_ptr + k) % NR]) w = (m_ptr + k) % NR;
                    end
                end
            end
            exp_gnt = (w >= 0) ? 4'(1 << w) : 4'd0;
            exp_st  = (w >= 0) ? {we[w], ~we[w], addr[w*AW +: AW], wdata[w*DW +: DW]} : 16'd0;
            exp_rv  = 4'd0;
            exp_rd  = 8'd0;
            if (pend.size() > 0 && pend[0].due == cyc) begin
                if (rst) begin
                    exp_rv = 4'(1 << pend[0].id);
                    exp_rd = pend[0].data;
                end
                void'(pend.pop_front());
            end
            check("rand.gnt", 64'(gnt), 64'(exp_gnt));
            check("rand.rvalid", 64'(rvalid), 64'(exp_rv));
            check("rand.steer", 64'({mem_write_en, mem_read_en, mem_addr, mem_data_in}),
                  64'(exp_st));
            if (exp_rv != 4'd0) check("rand.rdata", 64'(rdata), 64'(exp_rd));
            // Model update.
            if (!rst) begin
                m_owned = 1'b0; m_ptr = 0; m_owner = 0; m_cnt = 0;
                pend.delete();
            end else begin
                if (w >= 0) begin
                    a = int'(addr[w*AW +: AW]);
                    if (we[w]) begin
                        ref_mem[a] = wdata[w*DW +: DW];
                    end else begin
                        t_rd.due = cyc + 2; t_rd.id = w; t_rd.data = ref_mem[a];
                        pend.push_back(t_rd);
                    end
                end
                if (m_owned) begin
                    if (w < 0) begin
                        m_owned = 1'b0;
                        m_ptr   = (m_owner + 1) % NR;
                    end else begin
                        m_cnt++;
                        if (!lock[w] || m_cnt >= MB) begin
                            m_owned = 1'b0;
                            m_ptr   = (w + 1) % NR;
                        end
                    end
                end else if (w >= 0) begin
                    if (!(PRIO0 && w == 0)) m_ptr = (w + 1) % NR;
                    if (lock[w] && MB > 1) begin
                        m_owned = 1'b1; m_owner = w; m_cnt = 1;
                    end
                end
            end
            cyc++;
            @(posedge clk);
            #1;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_bank_arbiter.md
Name: mem_bank_arbiter

Overview:
- Shares one single-port memory_bank instance between NUM_REQ requesters.
- Arbitration is round-robin, with an optional per-requester burst lock.
- Winning requester's command is steered onto the bank ports in the same cycle.
- Read return (2-cycle bank latency) is tracked in a shadow pipeline and rvalid is routed back to the issuing requester.

Parameters:
- NUM_REQ, 4: number of requesters; 2 to 8.
- DATA_WIDTH, 8: bank data width.
- ADDR_WIDTH, 6: bank address width.
- MAX_BURST, 4: maximum consecutive grants a locked owner may take before forced release; at least 1.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-low reset.
- req  in  NUM_REQ  per-requester command request; held until granted.
- lock  in  NUM_REQ  per-requester burst-lock request; sampled with req.
- we  in  NUM_REQ  command type: 1 = write, 0 = read.
- addr  in  NUM_REQ*ADDR_WIDTH  packed addresses; requester i occupies slice [i*ADDR_WIDTH +: ADDR_WIDTH].
- wdata  in  NUM_REQ*DATA_WIDTH  packed write data, same slicing scheme.
- gnt  out  NUM_REQ  one-hot, combinational; command accepted this cycle.
- rvalid  out  NUM_REQ  one-hot, registered; read data for requester i is valid this cycle.
- rdata  out  DATA_WIDTH  shared read data, equal to mem_data_out.
- mem_write_en  out  1  to bank write_en.
- mem_read_en  out  1  to bank read_en.
- mem_addr  out  ADDR_WIDTH  to bank addr.
- mem_data_in  out  DATA_WIDTH  to bank data_in.
- mem_data_out  in  DATA_WIDTH  from bank data_out.

Behaviour:
- Reset (rst=0 at clk edge):
  - ptr and owner reset to 0; burst_cnt reset to 0; FSM to IDLE; read pipeline cleared.
  - While rst=0, gnt=0, rvalid=0, and mem_write_en=mem_read_en=0.
  - The top level drives the bank's active-high rst from ~rst.
- Datapath steering:
  - No grant: mem_write_en=0, mem_read_en=0, mem_addr=0, mem_data_in=0.
  - Grant to w: mem_write_en=we[w], mem_read_en=~we[w], mem_addr=addr slice w, mem_data_in=wdata slice w.
- FSM IDLE:
  - Winner is the first asserted req scanning from ptr upward, modulo NUM_REQ.
  - gnt[winner]=1 and ptr <= winner+1 mod NUM_REQ.
  - If lock[winner]=1: next state OWNED, owner <= winner, burst_cnt <= 1.
- FSM OWNED:
  - Only the owner is eligible; all other req are ignored and get gnt=0.
  - req[owner]=1: gnt[owner]=1 and burst_cnt increments.
  - Return to IDLE after a grant with lock[owner]=0, OR a cycle with req[owner]=0 (no grant that cycle), OR a grant that makes burst_cnt reach MAX_BURST.
  - On exit, ptr <= owner+1 mod NUM_REQ.
- Read return:
  - Read granted in cycle T sets stage1 <= {valid, id} at edge T.
  - stage2 <= stage1 at edge T+1.
  - rvalid[id] is high during cycle T+2; rdata=mem_data_out in that cycle.
  - Reads can be issued every cycle, interleaved with writes, with no bubbles; each rvalid is a single cycle.
- Ordering:
  - A write granted at T is visible to any read granted at T+1 or later.
  - A write at T does not disturb a read in flight from T-1 or T-2.
- Boundaries:
  - A requester dropping req without a grant is legal; nothing is issued.
  - Reset mid-read cancels all pending rvalid.
  - NUM_REQ not a power of two: ptr wraps from NUM_REQ-1 to 0.
  - MAX_BURST=1: lock has no effect on sharing.
- Fairness: with all NUM_REQ requesters permanently asserting req and lock=0, each requester is granted once per NUM_REQ cycles.

Optional Feature:
- Macro: MEM_ARB_PRIO0_EN.
- Defined:
  - Requester 0 is fixed highest priority in IDLE; it wins whenever req[0]=1, regardless of ptr.
  - ptr updates only on grants to requesters 1..NUM_REQ-1.
  - OWNED behaviour is unchanged, so another requester's lock still blocks requester 0 until release.
- Undefined: pure round-robin as described in Behaviour.

Test Plan:
- Reset: hold rst=0 for 3 cycles with all req=1 -> gnt=0, rvalid=0, mem_write_en=0 and mem_read_en=0 throughout; first grant after release goes to requester 0.
- Write then read:
  - Stimulus: req1 writes 0xA5 to 0x10 at cycle T; req2 reads 0x10 at T+1.
  - Response: gnt[1] at T, gnt[2] at T+1; rvalid[2]=1 at T+3 with rdata=0xA5; no other rvalid.
- Round-robin: all 4 requesters read continuously from addrs 0..3 (preloaded 0x11, 0x22, 0x33, 0x44) -> grant order 0,1,2,3,0,...; rvalid one-hot in the same order, 2 cycles later, with matching data.
- Burst lock:
  - Stimulus: MAX_BURST=4; req0 with lock=1 holds continuously; req1 also asserted.
  - Response: gnt[0] for 4 consecutive cycles, then gnt[1], then gnt[0] again.
- Reset mid-operation: read granted to req3 at T, rst=0 at T+1 -> rvalid stays 0 at T+2 and T+3.
- Macro: req0 and req1 continuous, lock=0 -> with MEM_ARB_PRIO0_EN, gnt[0] every cycle; without it, gnt alternates 0,1,0,1.
